punt_wait_ctrl: RTL and testbench
=================================

Name: punt_wait_ctrl

Overview:
- Generalised punt/wait-state controller for the CD32 riser CPLD.
- Decodes NCH parameterised address windows, claims the bus cycle via PUNT_OUT and holds the 68020 in wait states.
- Raises a per-channel interrupt to the STM32 and terminates the cycle with 8-bit DSACK on a rising edge of the STM32 ack line.
- Adds what the fixed-window version lacks: runtime channel enables, a reported channel index, abort handling, and a timeout that ends with bus error.

Parameters:
- NCH, 4, number of address windows/channels (1..16).
- ADDR_W, 24, CPU address width.
- CW, 2, channel index width; must satisfy 2^CW >= NCH.
- BASES, {24'hBFE001,24'hDFF00A,24'hD80000,24'hDC0000}, flattened NCH*ADDR_W window bases; channel i is bits [i*ADDR_W +: ADDR_W].
- MASKS, {24'hFFFFFF,24'hFFFFF8,24'hFFFF00,24'hFFFF00}, flattened compare masks; a 1 bit is compared.
- TIMEOUT, 4096, CLKCPU_A cycles allowed in WAIT_ACK before bus error.
- TO_W, 12, timeout counter width; must satisfy 2^TO_W >= TIMEOUT.

Ports:
- CLKCPU_A  in  1  CPU clock; all state changes on its rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- AS20  in  1  CPU address strobe, active low.
- DS20  in  1  CPU data strobe, active low.
- A  in  ADDR_W  CPU address.
- PUNT_IN  in  1  accelerator punt; high means the cycle is available.
- PUNT_OUT  out  1  driven 0 or Z.
- CH_EN  in  NCH  per-channel enable.
- ACK_IN  in  1  STM32 release line, asynchronous.
- DSACK  out  2  CPU data acknowledge, driven or ZZ.
- BERR  out  1  bus error; driven 0 or Z.
- INT_REQ  out  NCH  one-hot interrupt to the STM32.
- CH_ID  out  CW  index of the claimed channel.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Window hit: hit[i] = CH_EN[i] & ((A & MASK_i) == (BASE_i & MASK_i)).
- any_hit = |hit. If several windows hit, the lowest index wins.
- PUNT_OUT is combinational: PUNT_IN ? (any_hit ? 0 : Z) : 0. It is not strobe-gated and has no reset dependence.
- ACK_IN path: 2-flop synchroniser, then a registered edge flag ack_rise = (s1 & ~s2_d).
- Edge-to-state latency is 3 clocks. A level already high at claim time never releases a cycle; only a fresh rising edge does.
- FSM states: IDLE, WAIT_ACK, TERM, ERR.
- IDLE:
  - Claim when AS20=0, DS20=0, PUNT_IN=1 and any_hit are all true in the same sample.
  - On claim: latch the winning index into CH_ID, set INT_REQ to one-hot(CH_ID), clear the timeout counter, go to WAIT_ACK.
  - INT_REQ appears 1 clock after the sampling edge.
- WAIT_ACK:
  - DSACK = 2'b11 (wait states); the counter increments each clock.
  - Priority of exits: AS20=1 (abort) first, then ack_rise, then counter==TIMEOUT-1.
  - Abort goes to IDLE with INT_REQ cleared.
  - ack_rise goes to TERM.
  - Timeout goes to ERR.
- TERM:
  - DSACK = 2'b10 (8-bit port); INT_REQ cleared on entry.
  - Hold until AS20 is sampled high, then go to IDLE.
  - DSACK returns to ZZ on the same edge that enters IDLE.
- ERR:
  - DSACK = ZZ, BERR = 0, INT_REQ cleared.
  - Hold until AS20 is sampled high, then go to IDLE with BERR = Z.
- DSACK is ZZ in IDLE and ERR and is driven only in WAIT_ACK/TERM. BERR is driven only in ERR.
- Back-to-back cycles: a new claim is possible on the first IDLE clock. Claims require AS20 low, so no cycle is re-claimed while the strobe is still high.
- CH_EN changes mid-cycle do not affect an already claimed channel. They do affect PUNT_OUT immediately.
- Reset (async, any state) forces:
  - state IDLE, INT_REQ = 0, CH_ID = 0, counter = 0, synchroniser flops = 0;
  - DSACK = ZZ, BERR = Z, BUSY = 0.
- After RESETn deasserts, the first claim is possible on the next qualifying edge.

Test Plan (default parameters):
- Read of $DC0010 with CH_EN=4'b1111, PUNT_IN=1 -> PUNT_OUT=0; INT_REQ=4'b0001 and CH_ID=0 one clock after DS20 sampled low; DSACK=2'b11; ACK_IN pulse -> DSACK=2'b10 within 3-4 clocks; AS20 high -> DSACK=ZZ, BUSY=0.
- Access $DFF00C with CH_EN=4'b1011 -> PUNT_OUT=Z, INT_REQ stays 0, DSACK=ZZ. Same access with CH_EN=4'b1111 -> INT_REQ=4'b0100, CH_ID=2.
- Access $BFE001 with ACK_IN already high -> no release; the cycle stays in wait states until ACK_IN goes low then high, then DSACK=2'b10.
- Access $D80004 with no ack -> after 4096 clocks DSACK=ZZ and BERR=0, INT_REQ cleared; AS20 high -> BERR=Z, IDLE.
- PUNT_IN=0 during a $DC0000 access -> PUNT_OUT=0, no claim, INT_REQ=0, DSACK=ZZ.
- RESETn pulsed low during WAIT_ACK on channel 3 -> DSACK=ZZ, INT_REQ=0, BUSY=0 immediately. AS20 raised mid-WAIT_ACK (no reset) -> next clock IDLE, no DSACK 2'b10 issued.

Source files
------------

// File: rtl/punt_wait_ctrl.sv
// punt_wait_ctrl: claims CPU cycles in programmable windows, waits for STM32 ack, ends with 8-bit DSACK or BERR
module punt_wait_ctrl #(
  parameter int NCH = 4,
  parameter int ADDR_W = 24,
  parameter int CW = 2,
  parameter logic [NCH*ADDR_W-1:0] BASES = {24'hBFE001, 24'hDFF00A, 24'hD80000, 24'hDC0000},
  parameter logic [NCH*ADDR_W-1:0] MASKS = {24'hFFFFFF, 24'hFFFFF8, 24'hFFFF00, 24'hFFFF00},
  parameter int TIMEOUT = 4096,
  parameter int TO_W = 12
) (
  input  logic              CLKCPU_A,
  input  logic              RESETn,
  input  logic              AS20,
  input  logic              DS20,
  input  logic [ADDR_W-1:0] A,
  input  logic              PUNT_IN,
  output tri logic          PUNT_OUT,
  input  logic [NCH-1:0]    CH_EN,
  input  logic              ACK_IN,
  output tri logic [1:0]    DSACK,
  output tri logic          BERR,
  output logic [NCH-1:0]    INT_REQ,
  output logic [CW-1:0]     CH_ID,
  output logic              BUSY
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_ACK = 2'd1, TERM = 2'd2, ERR = 2'd3;
  logic [1:0] state;
  logic [TO_W-1:0] cnt;
  logic s1, s2, ack_rise, any_hit, claim;
  logic [NCH-1:0] hit;
  logic [CW-1:0] win;
  // descending scan so the lowest hitting index is the one left in win
  always_comb begin
    hit = '0;
    win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      hit[i] = CH_EN[i] & ((A & MASKS[i*ADDR_W +: ADDR_W]) == (BASES[i*ADDR_W +: ADDR_W] & MASKS[i*ADDR_W +: ADDR_W]));
      win = hit[i] ? CW'(i) : win;
    end
  end
  assign any_hit = |hit;
  assign claim = ~AS20 & ~DS20 & PUNT_IN & any_hit;
  assign PUNT_OUT = (PUNT_IN & ~any_hit) ? 1'bz : 1'b0;
  assign DSACK = (state == WAIT_ACK) ? 2'b11 : (state == TERM) ? 2'b10 : 2'bzz;
  assign BERR = (state == ERR) ? 1'b0 : 1'bz;
  assign INT_REQ = (state == WAIT_ACK) ? NCH'(1) << CH_ID : '0;
  assign BUSY = state != IDLE;
  always_ff @(posedge CLKCPU_A or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      cnt <= '0;
      CH_ID <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      ack_rise <= 1'b0;
    end else begin
      s1 <= ACK_IN;
      s2 <= s1;
      ack_rise <= s1 & ~s2;
      case (state)
        IDLE: if (claim) begin
          CH_ID <= win;
          cnt <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          cnt <= cnt + 1'b1;
          state <= AS20 ? IDLE : ack_rise ? TERM : (cnt == TO_W'(TIMEOUT - 1)) ? ERR : WAIT_ACK;
        end
        default: state <= AS20 ? IDLE : state;
      endcase
    end
  end
endmodule

// File: tb/tb_punt_wait_ctrl.sv
// tb_punt_wait_ctrl: directed scenarios plus randomized cycles against a window-table model
module tb_punt_wait_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, as20 = 1'b1, ds20 = 1'b1, punt_in = 1'b0, ack_in = 1'b0;
  logic [23:0] a = '0;
  logic [3:0] ch_en = '0;
  logic [3:0] int_req;
  logic [1:0] ch_id;
  logic busy;
  // pulls make released lines observable: PUNT_OUT/BERR float to 1, DSACK floats to 00
  tri1 punt_out;
  tri1 berr;
  tri0 [1:0] dsack;
  localparam logic [1:0] DS_Z = 2'b00;
  int vec = 0, err = 0;
  logic [23:0] base_m [4] = '{24'hDC0000, 24'hD80000, 24'hDFF00A, 24'hBFE001};
  logic [23:0] mask_m [4] = '{24'hFFFF00, 24'hFFFF00, 24'hFFFFF8, 24'hFFFFFF};

  punt_wait_ctrl dut (
    .CLKCPU_A(clk), .RESETn(rst_n), .AS20(as20), .DS20(ds20), .A(a), .PUNT_IN(punt_in),
    .PUNT_OUT(punt_out), .CH_EN(ch_en), .ACK_IN(ack_in), .DSACK(dsack), .BERR(berr),
    .INT_REQ(int_req), .CH_ID(ch_id), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_ch(input logic [23:0] addr, input logic [3:0] en);
    for (int i = 0; i < 4; i++)
      if (en[i] && ((addr & mask_m[i]) == (base_m[i] & mask_m[i]))) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic [3:0] en, input logic p);
    a = addr;
    ch_en = en;
    punt_in = p;
    as20 = 1'b0;
    ds20 = 1'b0;
  endtask

  task automatic end_cycle();
    as20 = 1'b1;
    ds20 = 1'b1;
    ack_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (int_req !== 4'b0) begin err++; $display("FAIL reset_int: got %b want 0000", int_req); end
    vec++; if (ch_id !== 2'd0) begin err++; $display("FAIL reset_chid: got %0d want 0", ch_id); end
    vec++; if (dsack !== DS_Z) begin err++; $display("FAIL reset_dsack: got %b want released", dsack); end
    vec++; if (berr !== 1'b1) begin err++; $display("FAIL reset_berr: got %b want released", berr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_claim_ch0();
    int n;
    start_cycle(24'hDC0010, 4'b1111, 1'b1);
    #1;
    vec++; if (punt_out !== 1'b0) begin err++; $display("FAIL ch0_punt: got %b want 0", punt_out); end
    tick();
    vec++; if (int_req !== 4'b0001) begin err++; $display("FAIL ch0_int: got %b want 0001", int_req); end
    vec++; if (ch_id !== 2'd0) begin err++; $display("FAIL ch0_chid: got %0d want 0", ch_id); end
    vec++; if (dsack !== 2'b11) begin err++; $display("FAIL ch0_wait: got %b want 11", dsack); end
    ack_in = 1'b1;
    tick();
    tick();
    vec++; if (dsack !== 2'b11) begin err++; $display("FAIL ch0_early: got %b want 11", dsack); end
    n = 2;
    while (dsack !== 2'b10 && n < 4) begin tick(); n++; end
    vec++; if (dsack !== 2'b10) begin err++; $display("FAIL ch0_term: got %b want 10", dsack); end
    vec++; if (int_req !== 4'b0) begin err++; $display("FAIL ch0_term_int: got %b want 0000", int_req); end
    end_cycle();
    vec++; if (dsack !== DS_Z || busy !== 1'b0) begin err++; $display("FAIL ch0_idle: got dsack=%b busy=%b want released/0", dsack, busy); end
  endtask

  task automatic test_enable();
    start_cycle(24'hDFF00C, 4'b1011, 1'b1);
    #1;
    vec++; if (punt_out !== 1'b1) begin err++; $display("FAIL en_punt_off: got %b want released", punt_out); end
    tick();
    vec++; if (int_req !== 4'b0 || busy !== 1'b0 || dsack !== DS_Z) begin err++; $display("FAIL en_noclaim: got int=%b busy=%b dsack=%b", int_req, busy, dsack); end
    ch_en = 4'b1111;
    #1;
    vec++; if (punt_out !== 1'b0) begin err++; $display("FAIL en_punt_on: got %b want 0", punt_out); end
    tick();
    vec++; if (int_req !== 4'b0100 || ch_id !== 2'd2) begin err++; $display("FAIL en_claim: got int=%b id=%0d want 0100/2", int_req, ch_id); end
    ch_en = 4'b0000;
    #1;
    vec++; if (punt_out !== 1'b1) begin err++; $display("FAIL en_mid_punt: got %b want released", punt_out); end
    tick();
    vec++; if (int_req !== 4'b0100 || dsack !== 2'b11) begin err++; $display("FAIL en_mid_hold: got int=%b dsack=%b want 0100/11", int_req, dsack); end
    end_cycle();
    vec++; if (busy !== 1'b0 || int_req !== 4'b0 || dsack !== DS_Z) begin err++; $display("FAIL en_abort: got busy=%b int=%b dsack=%b", busy, int_req, dsack); end
  endtask

  task automatic test_ack_level();
    int n;
    ack_in = 1'b1;
    repeat (3) tick();
    start_cycle(24'hBFE001, 4'b1111, 1'b1);
    tick();
    vec++; if (int_req !== 4'b1000 || ch_id !== 2'd3) begin err++; $display("FAIL lvl_claim: got int=%b id=%0d want 1000/3", int_req, ch_id); end
    repeat (10) tick();
    vec++; if (dsack !== 2'b11) begin err++; $display("FAIL lvl_hold: got %b want 11", dsack); end
    ack_in = 1'b0;
    repeat (3) tick();
    vec++; if (dsack !== 2'b11) begin err++; $display("FAIL lvl_fall: got %b want 11", dsack); end
    ack_in = 1'b1;
    n = 0;
    while (dsack !== 2'b10 && n < 4) begin tick(); n++; end
    vec++; if (dsack !== 2'b10) begin err++; $display("FAIL lvl_term: got %b want 10", dsack); end
    end_cycle();
  endtask

  task automatic test_timeout();
    start_cycle(24'hD80004, 4'b1111, 1'b1);
    tick();
    vec++; if (int_req !== 4'b0010 || ch_id !== 2'd1) begin err++; $display("FAIL to_claim: got int=%b id=%0d want 0010/1", int_req, ch_id); end
    repeat (4095) tick();
    vec++; if (dsack !== 2'b11 || berr !== 1'b1) begin err++; $display("FAIL to_early: got dsack=%b berr=%b want 11/released", dsack, berr); end
    tick();
    vec++; if (dsack !== DS_Z || berr !== 1'b0) begin err++; $display("FAIL to_berr: got dsack=%b berr=%b want released/0", dsack, berr); end
    vec++; if (int_req !== 4'b0 || busy !== 1'b1) begin err++; $display("FAIL to_err_state: got int=%b busy=%b want 0000/1", int_req, busy); end
    tick();
    vec++; if (berr !== 1'b0) begin err++; $display("FAIL to_hold: got %b want 0", berr); end
    end_cycle();
    vec++; if (berr !== 1'b1 || busy !== 1'b0) begin err++; $display("FAIL to_release: got berr=%b busy=%b want released/0", berr, busy); end
  endtask

  task automatic test_no_punt();
    start_cycle(24'hDC0000, 4'b1111, 1'b0);
    #1;
    vec++; if (punt_out !== 1'b0) begin err++; $display("FAIL np_punt: got %b want 0", punt_out); end
    tick();
    vec++; if (int_req !== 4'b0 || dsack !== DS_Z || busy !== 1'b0) begin err++; $display("FAIL np_noclaim: got int=%b dsack=%b busy=%b", int_req, dsack, busy); end
    end_cycle();
  endtask

  task automatic test_abort_reset();
    start_cycle(24'hBFE001, 4'b1000, 1'b1);
    tick();
    vec++; if (int_req !== 4'b1000) begin err++; $display("FAIL ar_claim: got %b want 1000", int_req); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (dsack !== DS_Z || int_req !== 4'b0 || busy !== 1'b0 || ch_id !== 2'd0) begin err++; $display("FAIL ar_async: got dsack=%b int=%b busy=%b id=%0d", dsack, int_req, busy, ch_id); end
    as20 = 1'b1;
    ds20 = 1'b1;
    tick();
    rst_n = 1'b1;
    start_cycle(24'hDC0000, 4'b0001, 1'b1);
    tick();
    vec++; if (int_req !== 4'b0001 || busy !== 1'b1) begin err++; $display("FAIL ar_first_claim: got int=%b busy=%b want 0001/1", int_req, busy); end
    as20 = 1'b1;
    tick();
    vec++; if (dsack !== DS_Z || busy !== 1'b0 || int_req !== 4'b0) begin err++; $display("FAIL ar_abort: got dsack=%b busy=%b int=%b", dsack, busy, int_req); end
    ds20 = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [23:0] addr;
    logic [3:0] en;
    logic p;
    int c, n;
    for (int k = 0; k < 60; k++) begin
      c = $urandom_range(0, 3);
      addr = ($urandom_range(0, 7) == 0) ? 24'($urandom) : base_m[c] ^ (($urandom_range(0, 1) == 0) ? 24'h0 : {16'h0, 8'($urandom)});
      en = 4'($urandom);
      p = $urandom_range(0, 4) != 0;
      c = exp_ch(addr, en);
      start_cycle(addr, en, p);
      #1;
      vec++; if (punt_out !== ((p && c < 0) ? 1'b1 : 1'b0)) begin err++; $display("FAIL rnd_punt[%0d]: got %b a=%h en=%b p=%b", k, punt_out, addr, en, p); end
      tick();
      if (p && c >= 0) begin
        vec++; if (int_req !== 4'(1 << c) || ch_id !== 2'(c) || dsack !== 2'b11) begin err++; $display("FAIL rnd_claim[%0d]: got int=%b id=%0d dsack=%b want ch %0d", k, int_req, ch_id, dsack, c); end
        repeat ($urandom_range(0, 4)) tick();
        ack_in = 1'b1;
        n = 0;
        while (dsack !== 2'b10 && n < 6) begin tick(); n++; end
        vec++; if (dsack !== 2'b10 || int_req !== 4'b0) begin err++; $display("FAIL rnd_term[%0d]: got dsack=%b int=%b want 10/0000", k, dsack, int_req); end
      end else begin
        vec++; if (int_req !== 4'b0 || busy !== 1'b0) begin err++; $display("FAIL rnd_noclaim[%0d]: got int=%b busy=%b", k, int_req, busy); end
      end
      end_cycle();
      vec++; if (busy !== 1'b0 || dsack !== DS_Z) begin err++; $display("FAIL rnd_idle[%0d]: got busy=%b dsack=%b", k, busy, dsack); end
    end
  endtask

  initial begin
    test_reset();
    test_claim_ch0();
    test_enable();
    test_ack_level();
    test_timeout();
    test_no_punt();
    test_abort_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
